// File: rtl/spmv_merge_pkg.sv
// -----------------------------------------------------------------------------
// spmv_merge_pkg
//
// Shared definitions for the SpMV merge tree and its downstream reduction
// stage.
//
//   IDX_WIDTH    default row index width
//   VAL_WIDTH    default value width (two's complement)
//   idx_t        row index type
//   val_t        signed value type
//   TERM_IDX     all-ones index marking the end of a stream
//   elem_t       packed stream element {idx, val}; idx occupies the upper bits
//   acc_state_e  decoded view of the reduction accumulator
// -----------------------------------------------------------------------------
package spmv_merge_pkg;

   localparam int IDX_WIDTH = 32;
   localparam int VAL_WIDTH = 32;

   typedef logic        [IDX_WIDTH-1:0] idx_t;
   typedef logic signed [VAL_WIDTH-1:0] val_t;

   // End-of-stream marker; never summed, always passed through on its own.
   localparam idx_t TERM_IDX = '1;

   typedef struct packed {
      idx_t idx;
      val_t val;
   } elem_t;

   // ACC_EMPTY : nothing held
   // ACC_RUN   : a partial sum for an ordinary index is held
   // ACC_TERM  : a terminator is held and waiting to be forwarded
   typedef enum logic [1:0] {
      ACC_EMPTY = 2'd0,
      ACC_RUN   = 2'd1,
      ACC_TERM  = 2'd2
   } acc_state_e;

endpackage : spmv_merge_pkg

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
//
// Single-clock first-word-fall-through FIFO with a registered occupancy count.
// The head word is presented on rd_data_o whenever empty_o is low, so a
// consumer can inspect it before deciding to pop. A word written on edge t is
// visible at the head from the cycle after t.
//
// Parameters
//   WIDTH  word width in bits
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset; empties the FIFO
//   wr_en_i    write request; ignored while full_o is high
//   wr_data_i  word to write
//   rd_en_i    pop request; ignored while empty_o is high
//   rd_data_o  current head word (valid when empty_o is low)
//   full_o     count == DEPTH
//   empty_o    count == 0
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push;
   logic             do_pop;

   // Full/empty come straight from the registered count, so a pop in the
   // same cycle never frees room for a push while full.
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   assign do_push = wr_en_i & ~full_o;
   assign do_pop  = rd_en_i & ~empty_o;

   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy is tracked solely by the count.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // A write presented while full is lost; upstream must honour full_o.
   a_no_push_when_full : assert property (
      @(posedge clk_i) disable iff (rst_i) !(wr_en_i && full_o)
   );

endmodule : sync_fifo_fwft

// File: rtl/merge_add_stage.sv
// -----------------------------------------------------------------------------
// merge_add_stage
//
// Reduction stage behind the root atom of the SpMV merge tree. It accepts the
// index-sorted (idx, val) stream through its own input FIFO and collapses runs
// of equal index into a single element carrying the wrapped sum of the run.
// A terminator (idx == all ones) is never summed and is forwarded on its own.
//
// Parameters
//   IDX_WIDTH   row index width
//   VAL_WIDTH   value width (two's complement, sums wrap modulo 2^VAL_WIDTH)
//   DATA_WIDTH  IDX_WIDTH + VAL_WIDTH; index in the upper bits
//   FIFO_DEPTH  input FIFO entries (power of two, >= 2)
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   global_en        stage enable; low freezes all state and suppresses output
//   fifo_wr_en       push from the upstream root atom
//   data_in          element pushed
//   fifo_full        input FIFO full, back to the upstream atom
//   next_fifo_full   downstream FIFO full
//   next_fifo_wr_en  push into the downstream FIFO
//   data_out         held element {acc_idx, acc_sum}, valid with next_fifo_wr_en
// -----------------------------------------------------------------------------
module merge_add_stage #(
   parameter int IDX_WIDTH  = spmv_merge_pkg::IDX_WIDTH,
   parameter int VAL_WIDTH  = spmv_merge_pkg::VAL_WIDTH,
   parameter int DATA_WIDTH = IDX_WIDTH + VAL_WIDTH,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  global_en,
   input  logic                  fifo_wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  fifo_full,
   input  logic                  next_fifo_full,
   output logic                  next_fifo_wr_en,
   output logic [DATA_WIDTH-1:0] data_out
);

   import spmv_merge_pkg::*;

   // Terminator at this instance's index width.
   localparam logic [IDX_WIDTH-1:0] TERM_LOCAL = '1;

   // Sum with overflow discarded: both operands and result share one width.
   function automatic logic signed [VAL_WIDTH-1:0] wrap_add(
      input logic signed [VAL_WIDTH-1:0] a,
      input logic signed [VAL_WIDTH-1:0] b
   );
      return a + b;
   endfunction

   logic                         push;
   logic                         pop;
   logic                         emit;
   logic [DATA_WIDTH-1:0]        head;
   logic                         head_empty;
   logic                         head_vld;
   logic [IDX_WIDTH-1:0]         head_idx;
   logic signed [VAL_WIDTH-1:0]  head_val;

   logic                         acc_valid_q, acc_valid_d;
   logic [IDX_WIDTH-1:0]         acc_idx_q,   acc_idx_d;
   logic signed [VAL_WIDTH-1:0]  acc_sum_q,   acc_sum_d;
   acc_state_e                   acc_state;

   // global_en gates the push here so a frozen stage accepts nothing.
   assign push = fifo_wr_en & global_en;

   sync_fifo_fwft #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_in_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (push),
      .wr_data_i (data_in),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (head_empty)
   );

   assign head_vld = ~head_empty;
   assign head_idx = head[DATA_WIDTH-1 -: IDX_WIDTH];
   assign head_val = head[VAL_WIDTH-1:0];

   always_comb begin
      if (!acc_valid_q) begin
         acc_state = ACC_EMPTY;
      end else if (acc_idx_q == TERM_LOCAL) begin
         acc_state = ACC_TERM;
      end else begin
         acc_state = ACC_RUN;
      end
   end

   // Per-cycle decision. A run is only closed when a different index shows
   // up at the head: an empty FIFO says nothing about whether more of the
   // same index is still on its way. A held terminator, by contrast, is
   // complete and leaves as soon as downstream has room.
   always_comb begin
      acc_valid_d = acc_valid_q;
      acc_idx_d   = acc_idx_q;
      acc_sum_d   = acc_sum_q;
      pop         = 1'b0;
      emit        = 1'b0;
      if (global_en) begin
         unique case (acc_state)
            ACC_EMPTY: begin
               if (head_vld) begin
                  acc_valid_d = 1'b1;
                  acc_idx_d   = head_idx;
                  acc_sum_d   = head_val;
                  pop         = 1'b1;
               end
            end
            ACC_RUN: begin
               if (head_vld) begin
                  if (head_idx == acc_idx_q) begin
                     acc_sum_d = wrap_add(acc_sum_q, head_val);
                     pop       = 1'b1;
                  end else if (!next_fifo_full) begin
                     // Forward the finished run and start the next one on
                     // the same edge.
                     emit      = 1'b1;
                     acc_idx_d = head_idx;
                     acc_sum_d = head_val;
                     pop       = 1'b1;
                  end
               end
            end
            ACC_TERM: begin
               if (!next_fifo_full) begin
                  emit = 1'b1;
                  if (head_vld) begin
                     // Loading here, never summing, keeps back-to-back
                     // terminators separate.
                     acc_idx_d = head_idx;
                     acc_sum_d = head_val;
                     pop       = 1'b1;
                  end else begin
                     acc_valid_d = 1'b0;
                  end
               end
            end
            default: begin
               acc_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_valid_q <= 1'b0;
         acc_idx_q   <= '0;
         acc_sum_q   <= '0;
      end else begin
         acc_valid_q <= acc_valid_d;
         acc_idx_q   <= acc_idx_d;
         acc_sum_q   <= acc_sum_d;
      end
   end

   // The write strobe is decoded from registered state, so reset clears it
   // without waiting for a clock edge.
   assign next_fifo_wr_en = emit;
   assign data_out        = {acc_idx_q, acc_sum_q};

endmodule : merge_add_stage

// File: tb/tb_merge_add_stage.sv
module tb_merge_add_stage;
   import spmv_merge_pkg::*;

   localparam int DEPTH = 8;
   localparam int DW    = $bits(elem_t);

   logic          clk            = 1'b0;
   logic          rst            = 1'b1;
   logic          global_en      = 1'b1;
   logic          fifo_wr_en     = 1'b0;
   logic [DW-1:0] data_in        = '0;
   logic          next_fifo_full = 1'b0;
   logic          fifo_full;
   logic          next_fifo_wr_en;
   logic [DW-1:0] data_out;

   int    n_chk    = 0;
   int    n_err    = 0;
   int    emit_cnt = 0;
   bit    done     = 1'b0;
   elem_t exp_q[$];

   always #5 clk = ~clk;

   merge_add_stage #(
      .IDX_WIDTH  (IDX_WIDTH),
      .VAL_WIDTH  (VAL_WIDTH),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .global_en       (global_en),
      .fifo_wr_en      (fifo_wr_en),
      .data_in         (data_in),
      .fifo_full       (fifo_full),
      .next_fifo_full  (next_fifo_full),
      .next_fifo_wr_en (next_fifo_wr_en),
      .data_out        (data_out)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   function automatic elem_t mk(input idx_t i, input val_t v);
      elem_t e;
      e.idx = i;
      e.val = v;
      return e;
   endfunction

   // Reference: collapse each run of equal ordinary index into one element
   // whose value is the sum modulo 2^VAL_WIDTH; terminators stand alone.
   task automatic model_stream(input elem_t s[$]);
      longint sum  = 0;
      idx_t   cur  = '0;
      bit     open = 1'b0;
      foreach (s[k]) begin
         if (s[k].idx == TERM_IDX) begin
            if (open) exp_q.push_back(mk(cur, sum[VAL_WIDTH-1:0]));
            open = 1'b0;
            exp_q.push_back(s[k]);
         end else if (open && s[k].idx == cur) begin
            sum = sum + longint'(s[k].val);
         end else begin
            if (open) exp_q.push_back(mk(cur, sum[VAL_WIDTH-1:0]));
            cur  = s[k].idx;
            sum  = longint'(s[k].val);
            open = 1'b1;
         end
      end
   endtask

   // Presents one word only in a cycle where it will be accepted.
   task automatic push(input elem_t e);
      bit ok    = 1'b0;
      int tries = 0;
      while (!ok && tries <= 2000) begin
         @(negedge clk);
         ok         = global_en && !fifo_full;
         fifo_wr_en = ok;
         data_in    = e;
         @(posedge clk);
         tries++;
      end
      if (!ok) chk("push_accept", 64'(ok), 64'd1);
      #1 fifo_wr_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Output monitor: every emitted element must be the next one the model
   // expects.
   initial begin
      elem_t e;
      forever begin
         @(negedge clk);
         if (!rst && next_fifo_wr_en) begin
            emit_cnt++;
            if (exp_q.size() == 0) begin
               chk("spurious_emit", 64'(next_fifo_wr_en), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("emit%0d", emit_cnt), data_out, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      elem_t s[$];
      int    base;
      idx_t  ri;

      // Reset and idle
      #1;
      chk("rst_full", 64'(fifo_full), 64'd0);
      chk("rst_wr", 64'(next_fifo_wr_en), 64'd0);
      chk("rst_dout", data_out, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_full", 64'(fifo_full), 64'd0);
         chk("idle_wr", 64'(next_fifo_wr_en), 64'd0);
         chk("idle_dout", data_out, 64'd0);
      end
      @(posedge clk); #1;

      // Basic reduction
      s.delete();
      s.push_back(mk(3, 5)); s.push_back(mk(3, 7));
      s.push_back(mk(4, 1)); s.push_back(mk(TERM_IDX, 0));
      base = emit_cnt;
      model_stream(s);
      foreach (s[k]) push(s[k]);
      drain("basic");
      chk("basic_cnt", 64'(emit_cnt - base), 64'd3);

      // Back-to-back terminators
      s.delete();
      s.push_back(mk(5, 1)); s.push_back(mk(TERM_IDX, 3)); s.push_back(mk(TERM_IDX, 4));
      base = emit_cnt;
      model_stream(s);
      foreach (s[k]) push(s[k]);
      drain("dterm");
      chk("dterm_cnt", 64'(emit_cnt - base), 64'd3);

      // Terminator latency with a flushed accumulator: emits on edge t+2
      s.delete();
      s.push_back(mk(TERM_IDX, 9));
      model_stream(s);
      push(s[0]);
      @(negedge clk);
      chk("term_lat1", 64'(next_fifo_wr_en), 64'd0);
      @(negedge clk);
      chk("term_lat2", 64'(next_fifo_wr_en), 64'd1);
      drain("term_lat");

      // Backpressure: two words are consumed before the stall, so the
      // FIFO fills on the (DEPTH+2)-th push.
      s.delete();
      s.push_back(mk(3, 5));  s.push_back(mk(3, 7));
      s.push_back(mk(4, 1));  s.push_back(mk(TERM_IDX, 0));
      s.push_back(mk(10, 1)); s.push_back(mk(10, 2));
      s.push_back(mk(11, 3)); s.push_back(mk(12, 4));
      s.push_back(mk(12, 5)); s.push_back(mk(TERM_IDX, 0));
      base = emit_cnt;
      model_stream(s);
      next_fifo_full = 1'b1;
      for (int k = 0; k < 9; k++) push(s[k]);
      chk("bp_not_full", 64'(fifo_full), 64'd0);
      push(s[9]);
      chk("bp_full", 64'(fifo_full), 64'd1);
      @(negedge clk);
      chk("bp_acc", data_out, mk(3, 12));
      chk("bp_no_emit", 64'(emit_cnt - base), 64'd0);
      @(posedge clk); #1;
      next_fifo_full = 1'b0;
      drain("bp");
      chk("bp_cnt", 64'(emit_cnt - base), 64'd7);

      // Wrap-around sums
      s.delete();
      s.push_back(mk(9, 32'h7FFF_FFFF)); s.push_back(mk(9, 1));
      s.push_back(mk(TERM_IDX, 0));
      s.push_back(mk(6, 32'hFFFF_FFFF)); s.push_back(mk(6, 2));
      s.push_back(mk(TERM_IDX, 0));
      base = emit_cnt;
      model_stream(s);
      foreach (s[k]) push(s[k]);
      drain("wrap");
      chk("wrap_cnt", 64'(emit_cnt - base), 64'd4);

      // Freeze mid-stream with a push request held high
      s.delete();
      s.push_back(mk(20, 1)); s.push_back(mk(20, 2));
      s.push_back(mk(21, 5)); s.push_back(mk(TERM_IDX, 0));
      base = emit_cnt;
      model_stream(s);
      for (int k = 0; k < 3; k++) push(s[k]);
      global_en  = 1'b0;
      fifo_wr_en = 1'b1;
      data_in    = mk(22, 7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("frz_wr", 64'(next_fifo_wr_en), 64'd0);
         chk("frz_acc", data_out, mk(20, 3));
         @(posedge clk);
      end
      #1;
      fifo_wr_en = 1'b0;
      global_en  = 1'b1;
      chk("frz_no_emit", 64'(emit_cnt - base), 64'd0);
      push(s[3]);
      drain("frz");
      chk("frz_cnt", 64'(emit_cnt - base), 64'd3);

      // Asynchronous reset while holding (7,20) with three words queued
      push(mk(7, 5));
      push(mk(7, 15));
      next_fifo_full = 1'b1;
      push(mk(8, 1)); push(mk(8, 2)); push(mk(9, 3));
      base = emit_cnt;
      @(negedge clk);
      chk("arst_acc", data_out, mk(7, 20));
      #1 next_fifo_full = 1'b0;
      #1 chk("arst_pending", 64'(next_fifo_wr_en), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_wr", 64'(next_fifo_wr_en), 64'd0);
      chk("arst_dout", data_out, 64'd0);
      chk("arst_full", 64'(fifo_full), 64'd0);
      chk("arst_no_emit", 64'(emit_cnt - base), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      s.delete();
      s.push_back(mk(2, 2)); s.push_back(mk(TERM_IDX, 0));
      base = emit_cnt;
      model_stream(s);
      foreach (s[k]) push(s[k]);
      drain("arst");
      chk("arst_cnt", 64'(emit_cnt - base), 64'd2);

      // Randomized traffic with random backpressure and enable
      for (int st = 0; st < 3; st++) begin
         s.delete();
         for (int k = 0; k < 60; k++) begin
            ri = ($urandom_range(0, 7) == 0) ? TERM_IDX : idx_t'($urandom_range(0, 3));
            s.push_back(mk(ri, val_t'($urandom)));
         end
         s.push_back(mk(TERM_IDX, val_t'($urandom)));
         model_stream(s);
         done = 1'b0;
         fork
            begin
               foreach (s[k]) begin
                  push(s[k]);
                  if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge clk);
                  #1;
                  next_fifo_full = ($urandom_range(0, 3) == 0);
                  global_en      = ($urandom_range(0, 7) != 0);
               end
            end
         join
         next_fifo_full = 1'b0;
         global_en      = 1'b1;
         drain($sformatf("rand%0d", st));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_merge_add_stage
